// File: rtl/phy_link_partner.sv
// Behavioural HMC PHY link partner: power-up/lock timing, TS1 training with
// per-lane bit-slip alignment, then 2-cycle loopback once the link is ACTIVE.
module phy_link_partner #(
    parameter int DWIDTH       = 128,
    parameter int NUM_LANES    = 8,
    parameter int TX_READY_DLY = 8,
    parameter int RX_READY_DLY = 8,
    parameter int ALIGN_HOLD   = 16
) (
    input  logic                 clk_hmc,
    input  logic                 res_n_hmc,
    input  logic [DWIDTH-1:0]    phy_data_tx_link2phy,
    input  logic [NUM_LANES-1:0] phy_bit_slip,
    input  logic                 phy_init_cont_set,
    output logic [DWIDTH-1:0]    phy_data_rx_phy2link,
    output logic                 phy_tx_ready,
    output logic                 phy_rx_ready,
    output logic [2:0]           link_state,
    output logic                 lanes_aligned
);

    typedef enum logic [2:0] {
        ST_PWR_UP  = 3'd0,
        ST_RX_LOCK = 3'd1,
        ST_NULL    = 3'd2,
        ST_TS1     = 3'd3,
        ST_ACTIVE  = 3'd4
    } state_t;

    localparam int CNT_MAX = (TX_READY_DLY > RX_READY_DLY) ? TX_READY_DLY : RX_READY_DLY;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int AW      = $clog2(ALIGN_HOLD + 1);
    localparam logic [CW-1:0] TX_LAST   = CW'(TX_READY_DLY - 1);
    localparam logic [CW-1:0] RX_LAST   = CW'(RX_READY_DLY - 1);
    localparam logic [AW-1:0] HOLD_LAST = AW'(ALIGN_HOLD - 1);

    state_t              state_q;
    state_t              state_d;
    logic [CW-1:0]       dly_cnt;
    logic [AW-1:0]       align_cnt;
    logic [3:0]          seq;
    logic [3:0]          offs [NUM_LANES];
    logic [DWIDTH-1:0]   loop_pipe;
    logic [DWIDTH-1:0]   ts1_word;
    logic                all_zero;
    logic                tx_done;
    logic                rx_done;
    logic                hold_done;
    logic                stay_ts1;

    function automatic logic [15:0] rotl16(input logic [15:0] w, input logic [3:0] k);
        logic [31:0] t;
        t = {w, w} << k;
        return t[31:16];
    endfunction

    assign tx_done   = (state_q == ST_PWR_UP)  && (dly_cnt == TX_LAST);
    assign rx_done   = (state_q == ST_RX_LOCK) && (dly_cnt == RX_LAST);
    assign hold_done = lanes_aligned && (align_cnt == HOLD_LAST);
    assign stay_ts1  = (state_q == ST_TS1) && (state_d == ST_TS1);
    assign link_state = state_q;

    always_comb begin
        all_zero = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (offs[i] != 4'd0) all_zero = 1'b0;
        end
        // Gated so the flag reads 0 while reset is held, whatever the offsets are.
        lanes_aligned = all_zero & res_n_hmc;
    end

    always_comb begin
        ts1_word = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            ts1_word[16*i +: 16] = rotl16({4'hF, 4'h0, 4'h3, seq}, offs[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PWR_UP:  if (tx_done) state_d = ST_RX_LOCK;
            ST_RX_LOCK: if (rx_done) state_d = ST_NULL;
            ST_NULL:    if (phy_init_cont_set) state_d = ST_TS1;
            ST_TS1: begin
                if (!phy_init_cont_set) state_d = ST_NULL;
                else if (hold_done)     state_d = ST_ACTIVE;
            end
            ST_ACTIVE:  if (!phy_init_cont_set) state_d = ST_NULL;
            default:    state_d = ST_PWR_UP;
        endcase
    end

    always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
        if (!res_n_hmc) begin
            state_q <= ST_PWR_UP;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
        if (!res_n_hmc) begin
            dly_cnt      <= '0;
            align_cnt    <= '0;
            seq          <= 4'd0;
            phy_tx_ready <= 1'b0;
            phy_rx_ready <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                offs[i] <= 4'((3 * i + 1) % 16);
            end
        end else begin
            if (tx_done || rx_done)
                dly_cnt <= '0;
            else if (state_q == ST_PWR_UP || state_q == ST_RX_LOCK)
                dly_cnt <= dly_cnt + CW'(1);
            else
                dly_cnt <= '0;

            phy_tx_ready <= phy_tx_ready | tx_done;
            phy_rx_ready <= phy_rx_ready | rx_done;

            // seq and the hold count only run while training continues uninterrupted.
            seq       <= stay_ts1 ? seq + 4'd1 : 4'd0;
            align_cnt <= (stay_ts1 && lanes_aligned) ? align_cnt + AW'(1) : '0;

            if (state_q == ST_TS1) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (phy_bit_slip[i]) offs[i] <= offs[i] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_hmc or negedge res_n_hmc) begin
        if (!res_n_hmc) begin
            loop_pipe            <= '0;
            phy_data_rx_phy2link <= '0;
        end else begin
            // Clearing the pipe outside ACTIVE guarantees zeros right after entry.
            loop_pipe <= (state_q == ST_ACTIVE) ? phy_data_tx_link2phy : '0;
            case (state_q)
                ST_TS1:    phy_data_rx_phy2link <= ts1_word;
                ST_ACTIVE: phy_data_rx_phy2link <= loop_pipe;
                default:   phy_data_rx_phy2link <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_phy_link_partner.sv
// Randomized bench for phy_link_partner: a behavioural link model predicts every
// cycle's outputs into a queue that a negedge monitor pops and compares.
module tb_phy_link_partner;
  localparam int DW  = 128;
  localparam int NL  = 8;
  localparam int TXD = 8;
  localparam int RXD = 8;
  localparam int AH  = 16;
  localparam int EW  = DW + 6;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] tx_data;
  logic [NL-1:0] bit_slip;
  logic          init_set;
  logic [DW-1:0] rx_data;
  logic          tx_ready;
  logic          rx_ready;
  logic [2:0]    link_state;
  logic          lanes_aligned;

  phy_link_partner #(
    .DWIDTH(DW), .NUM_LANES(NL), .TX_READY_DLY(TXD), .RX_READY_DLY(RXD), .ALIGN_HOLD(AH)
  ) dut (
    .clk_hmc              (clk),
    .res_n_hmc            (rst_n),
    .phy_data_tx_link2phy (tx_data),
    .phy_bit_slip         (bit_slip),
    .phy_init_cont_set    (init_set),
    .phy_data_rx_phy2link (rx_data),
    .phy_tx_ready         (tx_ready),
    .phy_rx_ready         (rx_ready),
    .link_state           (link_state),
    .lanes_aligned        (lanes_aligned)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  // behavioural model: link phase, lane offsets, training sequence, history
  int            m_cyc;
  int            m_state;
  int            m_prev_state;
  logic [DW-1:0] m_prev_tx;
  int            m_k [NL];
  int            m_seq;
  int            m_hold;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_aligned();
    for (int i = 0; i < NL; i++) if (m_k[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] rot_left(input int w, input int k);
    int r;
    r = ((w << k) | (w >> (16 - k))) & 32'hFFFF;
    return r[15:0];
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_state = 0; m_prev_state = 0; m_prev_tx = '0; m_seq = 0; m_hold = 0;
    for (int i = 0; i < NL; i++) m_k[i] = (3 * i + 1) % 16;
  endtask

  // One rising edge of the model, given the inputs held during the past cycle.
  task automatic model_step(input logic [NL-1:0] slip, input logic init, input logic [DW-1:0] tx);
    logic [DW-1:0] d;
    int ns;
    bit al;
    al = model_aligned();
    d  = '0;
    if (m_state == 3) begin
      for (int i = 0; i < NL; i++) d[16*i +: 16] = rot_left(16'hF030 + m_seq, m_k[i]);
    end else if (m_state == 4 && m_prev_state == 4) begin
      d = m_prev_tx;
    end
    m_prev_state = m_state;
    m_prev_tx    = tx;
    if (m_cyc < 100000) m_cyc++;
    ns = m_state;
    if (m_state < 2) begin
      ns = (m_cyc >= TXD + RXD) ? 2 : (m_cyc >= TXD) ? 1 : 0;
    end else if (m_state == 2) begin
      ns = init ? 3 : 2;
    end else if (m_state == 3) begin
      if (!init) ns = 2;
      else if (al) begin
        m_hold++;
        if (m_hold == AH) ns = 4;
      end else m_hold = 0;
    end else if (!init) begin
      ns = 2;
    end
    if (m_state == 3) begin
      for (int i = 0; i < NL; i++) if (slip[i]) m_k[i] = (m_k[i] + 15) % 16;
    end
    m_seq = (m_state == 3 && ns == 3) ? (m_seq + 1) % 16 : 0;
    if (ns != 3) m_hold = 0;
    m_state = ns;
    exp_q.push_back({d, 3'(ns), (m_cyc >= TXD), (m_cyc >= TXD + RXD), model_aligned()});
  endtask

  // driver: inputs change 1 time unit after the edge
  task automatic cycle(input logic [NL-1:0] slip, input logic init, input logic [DW-1:0] tx);
    bit_slip = slip;
    init_set = init;
    tx_data  = tx;
    @(posedge clk);
    model_step(slip, init, tx);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [NL-1:0] train_slips(input int idle_rate);
    logic [NL-1:0] s;
    s = '0;
    for (int i = 0; i < NL; i++) begin
      if (m_k[i] != 0) s[i] = ($urandom_range(0, 1) == 1);
      else             s[i] = ($urandom_range(0, idle_rate) == 0);
    end
    return s;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},   DW'(link_state),    DW'(0));
    check({tag, "_tx_rdy"},  DW'(tx_ready),      DW'(0));
    check({tag, "_rx_rdy"},  DW'(rx_ready),      DW'(0));
    check({tag, "_data"},    rx_data,            '0);
    check({tag, "_aligned"}, DW'(lanes_aligned), DW'(0));
  endtask

  // scoreboard monitor
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rx_data",  rx_data,            e[EW-1:6]);
        check("state",    DW'(link_state),    DW'(e[5:3]));
        check("tx_ready", DW'(tx_ready),      DW'(e[2]));
        check("rx_ready", DW'(rx_ready),      DW'(e[1]));
        check("aligned",  DW'(lanes_aligned), DW'(e[0]));
      end
    end
  end

  initial begin
    int guard;
    rst_n = 1'b0; tx_data = '0; bit_slip = '0; init_set = 1'b0;
    model_reset();
    #3;
    check_reset_values("por");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // bring-up then idle in NULL
    repeat (TXD + RXD + 4) cycle('0, 1'b0, rand_data());

    // TS1 without slips, then a wrap on the lane that starts at offset 0
    repeat (4) cycle('0, 1'b1, rand_data());
    cycle(8'h20, 1'b1, rand_data());

    guard = 0;
    while (!model_aligned() && guard < 400) begin
      cycle(train_slips(1000000), 1'b1, rand_data());
      guard++;
    end
    check("align_budget", DW'(guard < 400), DW'(1));

    // partial hold, then a slip breaks alignment and the hold restarts
    repeat (5) cycle('0, 1'b1, rand_data());
    cycle(8'h01, 1'b1, rand_data());
    repeat (15) cycle(8'h01, 1'b1, rand_data());
    repeat (AH + 2) cycle('0, 1'b1, rand_data());

    // ACTIVE loopback
    cycle('0, 1'b1, DW'(128'hA5));
    repeat (30) cycle('0, 1'b1, rand_data());

    // drop out of ACTIVE, retrain with offsets kept, drop once inside TS1
    repeat (4) cycle('0, 1'b0, rand_data());
    repeat (6) cycle('0, 1'b1, rand_data());
    cycle('0, 1'b0, rand_data());
    repeat (AH + 6) cycle('0, 1'b1, rand_data());
    repeat (5) cycle('0, 1'b1, rand_data());

    // asynchronous reset in the middle of ACTIVE
    #5;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // random traffic after restart
    repeat (TXD + RXD + 2) cycle('0, 1'b0, rand_data());
    for (int n = 0; n < 400; n++) begin
      cycle(train_slips(31), ($urandom_range(0, 29) != 0), rand_data());
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
